alu_dut_top: RTL and testbench
==============================

# alu_dut_top

Registered, single-cycle-latency arithmetic/logic unit: the device under test of the ALU verification environment, driven through the shared ALU interface by the bench program. Each valid request (opcode plus two operands) produces one registered result and four status flags exactly one clock later. There is no backpressure: one operation may be issued every cycle.

## Interface
- WIDTH, default 8: operand and result width in bits; legal values are powers of two, at least 4.
- SHW, default $clog2(WIDTH): shift-amount width, taken from b[SHW-1:0].
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_in  input  1  request strobe; op, a and b are sampled when high.
- op  input  4  opcode (see Operation).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B, or the shift/rotate amount in b[SHW-1:0].
- valid_out  output  1  high for one cycle when result and flags hold a new value.
- result  output  WIDTH  operation result.
- carry  output  1  carry, borrow or shifted-out bit.
- zero  output  1  high when result is 0.
- negative  output  1  equal to result[WIDTH-1].
- overflow  output  1  signed overflow.

## Operation
Opcodes:
- 0 ADD: a+b. carry = carry-out.
- 1 SUB: a−b. carry = borrow, i.e. high when a<b unsigned.
- 2 AND, 3 OR, 4 XOR.
- 5 NOT: ~a.
- 6 SHL: a<<n. carry = last bit shifted out.
- 7 SHR: logical shift right. carry = last bit shifted out.
- 8 SRA: arithmetic shift right. carry = last bit shifted out.
- 9 ROL, 10 ROR: rotate by n. carry = 0.
- 11 INC: a+1. carry = carry-out.
- 12 DEC: a−1. carry = borrow.
- 13 MUL: low WIDTH bits of a*b (unsigned). carry = 1 if the high WIDTH bits are nonzero.
- 14 SLT: result = 1 if a<b signed, else 0.
- 15 EQ: result = 1 if a==b, else 0.

Rules:
- n = b[SHW-1:0].
- For a shift or rotate with n=0: result = a and carry = 0.
- carry = 0 for every opcode not listed above with a carry rule.
- overflow applies only to ADD, SUB, INC and DEC (two's-complement overflow). It is 0 for all other opcodes.
- zero and negative are derived from the new result for every opcode.
- All arithmetic wraps modulo 2^WIDTH.
- When valid_in is low, result and all flags hold their previous values, and valid_out = 0 on the next edge.

## Timing
- Reset (reset=0): valid_out, result, carry, zero, negative and overflow all go to 0 immediately, without waiting for a clock edge, and stay there while reset is low.
- The first request can be accepted at the first rising edge after reset is released.
- Latency: a request sampled at edge k appears on the outputs after edge k, with valid_out=1 during cycle k+1.
- Throughput: 1 operation per cycle. Back-to-back requests give consecutive valid_out pulses, with no bubbles.
- Reset asserted mid-stream: any in-flight result is discarded, and no valid_out is produced for it.
- Outputs come directly from registers; there is no combinational path from inputs to outputs.

## Test plan
- Reset: drive reset=0 between clock edges while valid_out=1. All outputs must be 0 before the next edge. After release, issue ADD 3+4: result 0x07 with valid_out exactly one cycle later.
- ADD carry and overflow (WIDTH=8):
  - 0xFF+0x01 → result 0x00, carry=1, zero=1, overflow=0.
  - 0x7F+0x01 → result 0x80, overflow=1, negative=1, carry=0.
- SUB and compares:
  - 0x05−0x07 → result 0xFE, carry=1, negative=1.
  - SLT a=0x80, b=0x01 → result 1.
  - EQ a=0x5A, b=0x5A → result 1.
- Shifts and rotates:
  - SHL 0x81 by 1 → 0x02, carry=1.
  - SRA 0x80 by 3 → 0xF0, carry=0.
  - ROR 0x01 by 1 → 0x80.
  - SHR 0x55 by 0 → 0x55, carry=0.
- MUL: 0x10*0x10 → result 0x00, carry=1, zero=1. 0x0F*0x03 → result 0x2D, carry=0.
- Streaming: issue 16 back-to-back requests, one per opcode, then drop valid_in. Expect 16 consecutive valid_out pulses in order, after which the outputs hold the last result with valid_out=0.

Source files
------------

// File: rtl/alu_dut_top_if.sv
// alu_dut_top_if: request/response bundle between the ALU bench and the ALU.
interface alu_dut_top_if #(
    parameter int WIDTH = 8
) ();
    logic             valid_in;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid_out;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             overflow;

    modport master (
        output valid_in, op, a, b,
        input  valid_out, result, carry, zero, negative, overflow
    );

    modport slave (
        input  valid_in, op, a, b,
        output valid_out, result, carry, zero, negative, overflow
    );
endinterface

// File: rtl/alu_dut_top.sv
// alu_dut_top: registered single-cycle ALU; every accepted request updates result and flags one edge later.
module alu_dut_top #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    alu_dut_top_if.slave  bus
);
    localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  AND = 4'd2,  OR  = 4'd3,
                           XOR = 4'd4,  NOT = 4'd5,  SHL = 4'd6,  SHR = 4'd7,
                           SRA = 4'd8,  ROL = 4'd9,  ROR = 4'd10, INC = 4'd11,
                           DEC = 4'd12, MUL = 4'd13, SLT = 4'd14, EQ  = 4'd15;
    localparam int M = WIDTH - 1;

    logic [WIDTH-1:0]   a, b, y, result_d, result_q;
    logic [SHW-1:0]     n;
    logic [WIDTH:0]     sum, dif, shl, shr, sra;
    logic [2*WIDTH-1:0] prod, rl, rr;
    logic               carry_d, overflow_d, carry_q, zero_q, negative_q, overflow_q, valid_q;

    assign a = bus.a;
    assign b = bus.b;
    assign n = b[SHW-1:0];
    // INC/DEC reuse the adder and subtractor with a constant second operand
    assign y    = (bus.op == INC || bus.op == DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    assign sum  = {1'b0, a} + {1'b0, y};
    assign dif  = {1'b0, a} - {1'b0, y};
    // One guard bit catches the last bit shifted out; it stays 0 when n is 0
    assign shl  = {1'b0, a} << n;
    assign shr  = {a, 1'b0} >> n;
    assign sra  = $signed({a, 1'b0}) >>> n;
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign rl   = {a, a} << n;
    assign rr   = {a, a} >> n;

    always_comb begin
        result_d   = a;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        case (bus.op)
            ADD, INC: begin
                result_d   = sum[M:0];
                carry_d    = sum[WIDTH];
                overflow_d = (a[M] == y[M]) && (sum[M] != a[M]);
            end
            SUB, DEC: begin
                result_d   = dif[M:0];
                carry_d    = dif[WIDTH];
                overflow_d = (a[M] != y[M]) && (dif[M] != a[M]);
            end
            AND: result_d = a & b;
            OR:  result_d = a | b;
            XOR: result_d = a ^ b;
            NOT: result_d = ~a;
            SHL: {carry_d, result_d} = shl;
            SHR: {result_d, carry_d} = shr;
            SRA: {result_d, carry_d} = sra;
            ROL: result_d = rl[2*WIDTH-1:WIDTH];
            ROR: result_d = rr[M:0];
            MUL: begin
                result_d = prod[M:0];
                carry_d  = |prod[2*WIDTH-1:WIDTH];
            end
            SLT: result_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            EQ:  result_d = {{(WIDTH-1){1'b0}}, a == b};
            default: result_d = a;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= bus.valid_in;
            if (bus.valid_in) begin
                result_q   <= result_d;
                carry_q    <= carry_d;
                zero_q     <= result_d == '0;
                negative_q <= result_d[M];
                overflow_q <= overflow_d;
            end
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_alu_dut_top.sv
// tb_alu_dut_top: directed-vector bench for the 8-bit ALU with hand-computed expectations.
module tb_alu_dut_top;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    alu_dut_top_if #(.WIDTH(8)) bus ();
    alu_dut_top #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    // Packed expectation: {result, carry, zero, negative, overflow}
    logic [11:0] stream_exp [16] = '{
        {8'h99, 4'b0010}, {8'h93, 4'b0010}, {8'h02, 4'b0000}, {8'h97, 4'b0010},
        {8'h95, 4'b0010}, {8'h69, 4'b0000}, {8'hB0, 4'b0010}, {8'h12, 4'b1000},
        {8'hF2, 4'b1010}, {8'hB4, 4'b0010}, {8'hD2, 4'b0010}, {8'h97, 4'b0010},
        {8'h95, 4'b0010}, {8'hC2, 4'b1010}, {8'h01, 4'b0000}, {8'h00, 4'b0100}
    };

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [11:0] exp);
        chk({tag, ".valid"}, 32'(bus.valid_out), 32'(v));
        chk({tag, ".res_flags"}, 32'({bus.result, bus.carry, bus.zero, bus.negative, bus.overflow}), 32'(exp));
    endtask

    task automatic run(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        reset = 1'b1;
        #3 reset = 1'b0;
        #1 chk_out("por", 1'b0, 12'h000);
        @(negedge clk);
        reset = 1'b1;
        run(4'd0, 8'h03, 8'h04);
        chk_out("add_3_4", 1'b1, {8'h07, 4'b0000});
        // Assert reset between edges while valid_out is high
        #2 reset = 1'b0;
        #1 chk_out("async_rst", 1'b0, 12'h000);
        @(negedge clk);
        reset = 1'b1;
        bus.valid_in = 1'b1;
        bus.op = 4'd0;
        bus.a = 8'h03;
        bus.b = 8'h04;
        chk_out("pre_edge", 1'b0, 12'h000);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        chk_out("add_after_rst", 1'b1, {8'h07, 4'b0000});

        run(4'd0, 8'hFF, 8'h01);  chk_out("add_carry", 1'b1, {8'h00, 4'b1100});
        run(4'd0, 8'h7F, 8'h01);  chk_out("add_ovf",   1'b1, {8'h80, 4'b0011});
        run(4'd1, 8'h05, 8'h07);  chk_out("sub_borrow",1'b1, {8'hFE, 4'b1010});
        run(4'd14, 8'h80, 8'h01); chk_out("slt",       1'b1, {8'h01, 4'b0000});
        run(4'd15, 8'h5A, 8'h5A); chk_out("eq",        1'b1, {8'h01, 4'b0000});
        run(4'd6, 8'h81, 8'h01);  chk_out("shl",       1'b1, {8'h02, 4'b1000});
        run(4'd8, 8'h80, 8'h03);  chk_out("sra",       1'b1, {8'hF0, 4'b0010});
        run(4'd10, 8'h01, 8'h01); chk_out("ror",       1'b1, {8'h80, 4'b0010});
        run(4'd7, 8'h55, 8'h00);  chk_out("shr_zero",  1'b1, {8'h55, 4'b0000});
        run(4'd13, 8'h10, 8'h10); chk_out("mul_hi",    1'b1, {8'h00, 4'b1100});
        run(4'd13, 8'h0F, 8'h03); chk_out("mul_lo",    1'b1, {8'h2D, 4'b0000});
        @(posedge clk);
        #1 chk_out("hold", 1'b0, {8'h2D, 4'b0000});

        // Back-to-back: one opcode per cycle, valid_in never drops
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.valid_in = 1'b1;
            bus.op = 4'(i);
            bus.a = 8'h96;
            bus.b = 8'h03;
            @(posedge clk);
            #1 chk_out($sformatf("stream_op%0d", i), 1'b1, stream_exp[i]);
        end
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.a = 8'h11;
        @(posedge clk);
        #1 chk_out("stream_hold", 1'b0, stream_exp[15]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
